// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard read-side controller.
package ps2_pkg;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_POP    = 2'd1,
      ST_DECODE = 2'd2,
      ST_EMIT   = 2'd3
   } ps2_state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_key_ev_t;

endpackage

// File: rtl/ps2_key_tracker.sv
// Held-key tracking and press counting. Decides whether a decoded key event
// is forwarded downstream; state only changes on a strobed event.
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter bit REPEAT_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ev_stb,
   input  ps2_key_ev_t      ev,
   output logic             emit,
   output logic [CNT_W-1:0] press_cnt,
   output logic             held_valid
);

   logic       held_ext;
   logic [7:0] held_code;
   logic       same_key;
   logic       do_press;
   logic       do_release;

   // Classify the strobed event against the held key (ext is part of identity).
   always_comb begin
      same_key   = held_valid && (held_ext == ev.ext) && (held_code == ev.code);
      emit       = 1'b0;
      do_press   = 1'b0;
      do_release = 1'b0;
      if (ev_stb) begin
         if (ev.brk) begin
            emit       = 1'b1;
            do_release = same_key;
         end else if (same_key) begin
            emit = REPEAT_EN;
         end else begin
            emit     = 1'b1;
            do_press = 1'b1;
         end
      end
   end

   // Held key register and wrapping press counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         press_cnt  <= '0;
         held_valid <= 1'b0;
         held_ext   <= 1'b0;
         held_code  <= 8'h00;
      end else if (do_press) begin
         press_cnt  <= press_cnt + CNT_W'(1);
         held_valid <= 1'b1;
         held_ext   <= ev.ext;
         held_code  <= ev.code;
      end else if (do_release) begin
         held_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 receiver FIFO consumer: pops scan bytes, folds E0/F0 prefixes into
// key events and hands them downstream with a valid/ready handshake.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_FETCH  | wait for kb_ready, latch head byte, request pop
//   ST_POP    | pop strobe (kb_nextdata_n low) is on the wire this cycle
//   ST_DECODE | prefix -> set flag; key byte -> build event, ask tracker
//   ST_EMIT   | event held stable until ev_ready; no popping here
module ps2_kbd_ctrl
   import ps2_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter bit REPEAT_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       kb_data,
   input  logic             kb_ready,
   input  logic             kb_overflow,
   output logic             kb_nextdata_n,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [7:0]       ev_code,
   output logic             ev_ext,
   output logic             ev_break,
   output logic [CNT_W-1:0] press_cnt,
   output logic             held_valid,
   output logic             err_ovf
);

   ps2_state_t  state_q, state_d;
   logic [7:0]  byte_q, byte_d;
   logic        ext_f, ext_d;
   logic        brk_f, brk_d;
   logic        nextdata_n_d;
   logic        ev_valid_d;
   logic [7:0]  ev_code_d;
   logic        ev_ext_d;
   logic        ev_break_d;
   logic        trk_stb;
   logic        trk_emit;
   ps2_key_ev_t trk_ev;

   assign trk_ev = '{ext: ext_f, brk: brk_f, code: byte_q};

   ps2_key_tracker #(
      .CNT_W     (CNT_W),
      .REPEAT_EN (REPEAT_EN)
   ) u_tracker (
      .clk        (clk),
      .rst        (rst),
      .ev_stb     (trk_stb),
      .ev         (trk_ev),
      .emit       (trk_emit),
      .press_cnt  (press_cnt),
      .held_valid (held_valid)
   );

   // Next-state and next-output logic; every registered output is computed here.
   always_comb begin
      state_d      = state_q;
      byte_d       = byte_q;
      ext_d        = ext_f;
      brk_d        = brk_f;
      nextdata_n_d = 1'b1;
      ev_valid_d   = ev_valid;
      ev_code_d    = ev_code;
      ev_ext_d     = ev_ext;
      ev_break_d   = ev_break;
      trk_stb      = 1'b0;
      unique case (state_q)
         ST_FETCH: begin
            if (kb_ready) begin
               byte_d       = kb_data;
               nextdata_n_d = 1'b0;
               state_d      = ST_POP;
            end
         end
         ST_POP: begin
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            state_d = ST_FETCH;
            if (byte_q == PS2_PFX_EXT) begin
               ext_d = 1'b1;
            end else if (byte_q == PS2_PFX_BRK) begin
               brk_d = 1'b1;
            end else begin
               trk_stb = 1'b1;
               ext_d   = 1'b0;
               brk_d   = 1'b0;
               if (trk_emit) begin
                  ev_code_d  = byte_q;
                  ev_ext_d   = ext_f;
                  ev_break_d = brk_f;
                  ev_valid_d = 1'b1;
                  state_d    = ST_EMIT;
               end
            end
         end
         ST_EMIT: begin
            if (ev_ready) begin
               ev_valid_d = 1'b0;
               state_d    = ST_FETCH;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_FETCH;
         byte_q        <= 8'h00;
         ext_f         <= 1'b0;
         brk_f         <= 1'b0;
         kb_nextdata_n <= 1'b1;
         ev_valid      <= 1'b0;
         ev_code       <= 8'h00;
         ev_ext        <= 1'b0;
         ev_break      <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_q        <= byte_d;
         ext_f         <= ext_d;
         brk_f         <= brk_d;
         kb_nextdata_n <= nextdata_n_d;
         ev_valid      <= ev_valid_d;
         ev_code       <= ev_code_d;
         ev_ext        <= ev_ext_d;
         ev_break      <= ev_break_d;
      end
   end

   // Sticky receiver-overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_ovf <= 1'b0;
      else     err_ovf <= err_ovf | kb_overflow;
   end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a receiver FIFO model feeds bytes, a
// key-level reference model predicts events, a monitor checks handshakes.
module tb_ps2_kbd_ctrl;
   import ps2_pkg::*;

   localparam int CNT_W = 8;
   localparam bit REP   = 1'b0;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       kb_data;
   logic             kb_ready;
   logic             kb_overflow;
   logic             kb_nextdata_n;
   logic             ev_valid;
   logic             ev_ready;
   logic [7:0]       ev_code;
   logic             ev_ext;
   logic             ev_break;
   logic [CNT_W-1:0] press_cnt;
   logic             held_valid;
   logic             err_ovf;

   always #5 clk = ~clk;

   ps2_kbd_ctrl #(.CNT_W(CNT_W), .REPEAT_EN(REP)) dut (
      .clk           (clk),
      .rst           (rst),
      .kb_data       (kb_data),
      .kb_ready      (kb_ready),
      .kb_overflow   (kb_overflow),
      .kb_nextdata_n (kb_nextdata_n),
      .ev_valid      (ev_valid),
      .ev_ready      (ev_ready),
      .ev_code       (ev_code),
      .ev_ext        (ev_ext),
      .ev_break      (ev_break),
      .press_cnt     (press_cnt),
      .held_valid    (held_valid),
      .err_ovf       (err_ovf)
   );

   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      int         cnt;
      logic       held;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] fifo_q[$];
   int         n_pass = 0;
   int         n_tot  = 0;
   int         n_pops = 0;
   int         n_ev   = 0;
   int         rdy_mode = 0;

   // Key-level reference state.
   bit         m_ext, m_brk, m_held, m_hext;
   logic [7:0] m_hcode;
   int         m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_hcode = 8'h00; m_cnt = 0;
   endtask

   // Queue a byte into the receiver FIFO and predict its effect at key level.
   task automatic send(input logic [7:0] b);
      bit   match;
      exp_t e;
      fifo_q.push_back(b);
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         match = m_held && (m_hext == m_ext) && (m_hcode == b);
         e.code = b; e.ext = m_ext; e.brk = m_brk;
         if (!m_brk) begin
            if (!match) begin
               m_cnt  = (m_cnt + 1) % (1 << CNT_W);
               m_held = 1; m_hext = m_ext; m_hcode = b;
               e.cnt = m_cnt; e.held = 1'b1;
               exp_q.push_back(e);
            end else if (REP) begin
               e.cnt = m_cnt; e.held = 1'b1;
               exp_q.push_back(e);
            end
         end else begin
            if (match) m_held = 0;
            e.cnt = m_cnt; e.held = m_held;
            exp_q.push_back(e);
         end
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic send_key(input logic [7:0] code, input bit ext, input bit brk);
      if (ext) send(8'hE0);
      if (brk) send(8'hF0);
      send(code);
   endtask

   task automatic check_reset();
      chk("rst_nextdata_n", kb_nextdata_n, 1);
      chk("rst_ev_valid",   ev_valid, 0);
      chk("rst_ev_code",    ev_code, 0);
      chk("rst_ev_ext",     ev_ext, 0);
      chk("rst_ev_break",   ev_break, 0);
      chk("rst_press_cnt",  press_cnt, 0);
      chk("rst_held_valid", held_valid, 0);
      chk("rst_err_ovf",    err_ovf, 0);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0 || ev_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_in_budget", n < budget, 1);
      repeat (6) @(negedge clk);
   endtask

   // Receiver FIFO model: pops on a low strobe, presents head byte.
   initial begin
      bit prev_low = 0;
      kb_ready = 1'b0;
      kb_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (kb_nextdata_n === 1'b0) begin
            chk("pop_width_1", prev_low, 0);
            chk("no_pop_in_emit", ev_valid, 0);
            chk("pop_nonempty", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            n_pops++;
            prev_low = 1;
         end else begin
            prev_low = 0;
         end
         kb_ready = (fifo_q.size() != 0);
         kb_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      end
   end

   // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
   initial begin
      ev_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       ev_ready = 1'b1;
            1:       ev_ready = ($urandom_range(0, 3) != 0);
            default: ev_ready = 1'b0;
         endcase
      end
   end

   // Monitor: latency, stability under back-pressure, scoreboard compare.
   initial begin
      bit         prev_v = 0, prev_r = 0;
      logic [9:0] prev_f = '0;
      int         since = 100;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 0; prev_r = 0; since = 100;
         end else begin
            since = (kb_nextdata_n === 1'b0) ? 0 : ((since < 100) ? since + 1 : since);
            if (ev_valid && !prev_v) chk("ev_latency", since, 2);
            if (ev_valid && prev_v && !prev_r)
               chk("ev_stable", {ev_ext, ev_break, ev_code}, prev_f);
            if (ev_valid && ev_ready) begin
               n_ev++;
               if (exp_q.size() == 0) begin
                  n_tot++;
                  $display("FAIL unexpected_event: got code %0h ext %0b brk %0b, expected none",
                           ev_code, ev_ext, ev_break);
               end else begin
                  e = exp_q.pop_front();
                  chk("ev_code",    ev_code, e.code);
                  chk("ev_ext",     ev_ext, e.ext);
                  chk("ev_break",   ev_break, e.brk);
                  chk("press_cnt",  press_cnt, e.cnt);
                  chk("held_valid", held_valid, e.held);
               end
            end
            prev_v = ev_valid;
            prev_r = ev_ready;
            prev_f = {ev_ext, ev_break, ev_code};
         end
      end
   end

   initial begin
      logic [7:0] keys[3];
      int         p0, e0, w;
      keys[0] = 8'h1C; keys[1] = 8'h32; keys[2] = 8'h75;
      rst = 1'b1;
      kb_overflow = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset();
      rst = 1'b0;

      // plain press / release
      p0 = n_pops;
      send_key(8'h1C, 0, 0);
      send_key(8'h1C, 0, 1);
      drain(500);
      chk("plain_pops", n_pops - p0, 3);
      chk("plain_cnt", press_cnt, 1);
      chk("plain_held", held_valid, 0);

      // extended key, then plain 75 as a distinct key
      send_key(8'h75, 1, 0);
      send_key(8'h75, 1, 1);
      send_key(8'h75, 0, 0);
      drain(500);
      chk("ext_cnt", press_cnt, 3);

      // typematic repeats
      e0 = n_ev;
      send_key(8'h1C, 0, 0);
      send_key(8'h1C, 0, 0);
      send_key(8'h1C, 0, 0);
      send_key(8'h1C, 0, 1);
      drain(500);
      chk("typematic_events", n_ev - e0, 2);
      chk("typematic_cnt", press_cnt, 4);

      // back-pressure: three bytes queued, downstream stalled
      rdy_mode = 2;
      send(8'h32); send(8'h1C); send(8'h75);
      w = 0;
      while (!ev_valid && w < 50) begin @(negedge clk); w++; end
      chk("bp_event_seen", ev_valid, 1);
      repeat (20) @(negedge clk);
      chk("bp_fifo_held", fifo_q.size(), 2);
      rdy_mode = 0;
      drain(500);
      chk("bp_cnt", press_cnt, 7);

      // randomized key traffic with random back-pressure
      rdy_mode = 1;
      for (int i = 0; i < 150; i++) begin
         send_key(keys[$urandom_range(0, 2)], $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0);
         if ($urandom_range(0, 9) == 0) send(8'hF0);
         if ($urandom_range(0, 4) == 0) @(negedge clk);
      end
      drain(20000);
      chk("rand_cnt", press_cnt, m_cnt);
      chk("rand_held", held_valid, m_held);
      rdy_mode = 0;

      // counter wrap and sticky overflow
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; model_reset();
      kb_overflow = 1'b1;
      @(negedge clk); kb_overflow = 1'b0;
      repeat (5) @(negedge clk);
      chk("ovf_sticky", err_ovf, 1);
      for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
      drain(5000);
      chk("wrap_cnt", press_cnt, 0);
      chk("ovf_still_set", err_ovf, 1);

      // reset after E0 F0 consumed
      send(8'hE0); send(8'hF0);
      drain(500);
      rst = 1'b1;
      #1;
      check_reset();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      send(8'h1C);
      drain(500);
      chk("post_rst_cnt", press_cnt, 1);
      chk("post_rst_held", held_valid, 1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
